if_stage: RTL

Instruction-fetch stage of the pipeline, directly upstream of the decode stage. It generates the fetch PC, issues requests to instruction memory over a request/grant/response handshake, and buffers up to two returned words in a small prefetch FIFO. It presents one instruction per cycle, with its extracted register and opcode fields, to decode. Bubbles are NOPs (ADDI x0,x0,0), so decode needs no valid input.

---
 rtl/if_stage_if.sv | 35 +++
 rtl/if_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// =============================================================================
// Module   : if_stage_if
// Desc     : Instruction-memory request/grant/response bus for the fetch stage.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

interface if_stage_if #(
    parameter int A_WIDTH = 32,
    parameter int D_WIDTH = 32
);
    logic               req;
    logic [A_WIDTH-1:0] addr;
    logic               gnt;
    logic               rvalid;
    logic [D_WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// =============================================================================
// Module   : if_stage
// Desc     : Instruction fetch with 2-deep prefetch FIFO and redirect support.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module if_stage #(
    parameter int                 D_WIDTH  = 32,
    parameter int                 A_WIDTH  = 32,
    parameter int                 N_REGS   = 32,
    parameter int                 RF_SIZE  = $clog2(N_REGS),
    parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               en,
    input  wire logic               redirect,
    input  wire logic [A_WIDTH-1:0] redirect_pc,
    if_stage_if.master              imem,
    output logic      [D_WIDTH-1:0] instr_id,
    output logic      [A_WIDTH-1:0] pc_id,
    output logic                    valid_id,
    output logic      [6:0]         opcode,
    output logic      [RF_SIZE-1:0] rd,
    output logic      [2:0]         funct3,
    output logic      [RF_SIZE-1:0] rs1,
    output logic      [RF_SIZE-1:0] rs2,
    output logic      [6:0]         funct7
);

    localparam logic [D_WIDTH-1:0] C_NOP     = D_WIDTH'(32'h0000_0013);
    localparam logic [A_WIDTH-1:0] C_PC_STEP = A_WIDTH'(4);

    logic [A_WIDTH-1:0] r_fetch_pc;
    logic [A_WIDTH-1:0] r_resp_pc;
    logic [1:0]         r_outstanding;
    logic [1:0]         r_drop;
    logic [1:0]         r_count;
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [A_WIDTH-1:0] r_fifo_pc    [2];
    logic [D_WIDTH-1:0] r_fifo_instr [2];

    logic               w_pop;
    logic               w_push;
    logic               w_req;
    logic               w_grant;

    // Requests are throttled so in-flight words plus buffered words never exceed two.
    assign w_pop   = en & (r_count != 2'd0) & ~redirect;
    assign w_req   = ~rst & ~redirect &
                     (({1'b0, r_outstanding} + {1'b0, r_count}) < (3'd2 + {2'b00, w_pop}));
    assign w_grant = w_req & imem.gnt;
    assign w_push  = imem.rvalid & (r_drop == 2'd0) & ~redirect;

    assign imem.req  = w_req;
    assign imem.addr = r_fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= 2'd0;
            r_drop        <= 2'd0;
        end else begin
            case ({w_grant, imem.rvalid})
                2'b10:   r_outstanding <= r_outstanding + 2'd1;
                2'b01:   r_outstanding <= r_outstanding - 2'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
                // Everything still in flight belongs to the abandoned path.
                r_drop     <= r_outstanding - {1'b0, imem.rvalid};
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + C_PC_STEP;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + C_PC_STEP;
                end
                if (imem.rvalid && (r_drop != 2'd0)) begin
                    r_drop <= r_drop - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else if (redirect) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
            r_fifo_instr[r_wr_ptr] <= imem.rdata;
        end
    end

    // With en high and no redirect, a non-empty FIFO always pops, so en alone
    // decides between head and bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_id <= C_NOP;
            pc_id    <= RESET_PC;
            valid_id <= 1'b0;
        end else if (redirect) begin
            instr_id <= C_NOP;
            valid_id <= 1'b0;
        end else if (en) begin
            if (w_pop) begin
                instr_id <= r_fifo_instr[r_rd_ptr];
                pc_id    <= r_fifo_pc[r_rd_ptr];
                valid_id <= 1'b1;
            end else begin
                instr_id <= C_NOP;
                valid_id <= 1'b0;
            end
        end
    end

    assign opcode = instr_id[6:0];
    assign rd     = instr_id[7 +: RF_SIZE];
    assign funct3 = instr_id[14:12];
    assign rs1    = instr_id[15 +: RF_SIZE];
    assign rs2    = instr_id[20 +: RF_SIZE];
    assign funct7 = instr_id[31:25];

endmodule

`default_nettype wire
